// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: word width, RAM handshake status and arbiter states.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // RAM status as reported back by the memory model / controller
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Which cache side currently owns the RAM port
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } arbstate_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants completed while an instruction fetch was
// waiting. hit_o tells the arbiter to hand the next grant to the I-side.
// Only instantiated when MEM_ARB_STARVE_EN is defined.
module arb_starve_ctr #(
  parameter int unsigned LIMIT = 4
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic hit_o
);

  localparam int unsigned CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear beats increment; saturate at LIM so hit stays asserted
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                    cnt_d = '0;
    else if (inc_i && cnt_q < LIM) cnt_d = cnt_q + CW'(1);
  end

  // Counter register
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign hit_o = (cnt_q >= LIM);

endmodule

// File: rtl/memory_arbiter.sv
// Two-port (I-cache / D-cache) arbiter onto a single RAM port.
// Data side wins by default; defining MEM_ARB_STARVE_EN adds a guard that
// forces an instruction grant after STARVE_LIMIT data grants taken while
// iREN was pending.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     iaddr,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      iwait,
  output logic      dwait,
  output word_t     iload,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      err
);

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("memory_arbiter: STARVE_LIMIT must be at least 1");
  end

  arbstate_t state_q, state_d;
  logic      err_q, err_d;
  logic      d_req;
  logic      starve_pick;

  assign d_req = dREN | dWEN;

`ifdef MEM_ARB_STARVE_EN
  logic i_done, d_done;

  assign i_done = (state_q == IACC) && iREN  && (ramstate == ACCESS);
  assign d_done = (state_q == DACC) && d_req && (ramstate == ACCESS);

  arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .gclk   (CLK),
    .grst_n (nRST),
    .inc_i  (d_done & iREN),
    .clr_i  (i_done),
    .hit_o  (starve_pick)
  );
`else
  assign starve_pick = 1'b0;
`endif

  // Next owner plus RAM-side mux; all outputs idle unless a grant is live
  always_comb begin
    state_d  = state_q;
    iwait    = 1'b1;
    dwait    = 1'b1;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    err_d    = err_q | ((state_q != IDLE) && (ramstate == ERROR));
    case (state_q)
      IDLE: begin
        if (iREN && starve_pick) state_d = IACC;
        else if (d_req)          state_d = DACC;
        else if (iREN)           state_d = IACC;
      end
      IACC: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        // A dropped request abandons the grant silently
        if (!iREN) state_d = IDLE;
        else if (ramstate == ACCESS) begin
          iwait   = 1'b0;
          iload   = ramload;
          state_d = IDLE;
        end
      end
      DACC: begin
        ramaddr = daddr;
        if (dWEN) begin
          ramWEN   = 1'b1;
          ramstore = dstore;
        end else begin
          ramREN   = 1'b1;
        end
        if (!d_req) state_d = IDLE;
        else if (ramstate == ACCESS) begin
          dwait   = 1'b0;
          if (!dWEN) dload = ramload;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Owner and sticky error flag
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level
// owner model. Honours MEM_ARB_STARVE_EN the same way the design does.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int LIMIT = 4;
`ifdef MEM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic      CLK = 1'b0;
  logic      nRST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore;
  logic      iwait, dwait;
  word_t     iload, dload;
  logic      ramREN, ramWEN;
  word_t     ramaddr, ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      err;

  always #5 CLK = ~CLK;

  memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // owner: 0 = nobody, 1 = instruction side, 2 = data side
  typedef struct packed {
    logic  iwait, dwait, ramREN, ramWEN, err;
    word_t ramaddr, ramstore, iload, dload;
  } outs_t;

  int   own, own_n;
  int   cnt, cnt_n;
  logic m_err, m_err_n;

  function automatic outs_t model_outs();
    outs_t o;
    o = '{iwait: 1'b1, dwait: 1'b1, ramREN: 1'b0, ramWEN: 1'b0, err: m_err,
          ramaddr: '0, ramstore: '0, iload: '0, dload: '0};
    if (own == 1) begin
      o.ramREN  = 1'b1;
      o.ramaddr = iaddr;
      if (iREN && ramstate == ACCESS) begin
        o.iwait = 1'b0;
        o.iload = ramload;
      end
    end else if (own == 2) begin
      o.ramaddr  = daddr;
      o.ramWEN   = dWEN;
      o.ramREN   = !dWEN;
      o.ramstore = dWEN ? dstore : 32'h0;
      if ((dREN || dWEN) && ramstate == ACCESS) begin
        o.dwait = 1'b0;
        o.dload = dWEN ? 32'h0 : ramload;
      end
    end
    return o;
  endfunction

  // Who owns the RAM next cycle, given this cycle's inputs
  function automatic void model_next();
    bit done;
    own_n   = own;
    cnt_n   = cnt;
    m_err_n = m_err || (own != 0 && ramstate == ERROR);
    done    = (ramstate == ACCESS);
    if (own == 0) begin
      if (STARVE && iREN && cnt >= LIMIT) own_n = 1;
      else if (dREN || dWEN)              own_n = 2;
      else if (iREN)                      own_n = 1;
    end else if (own == 1) begin
      if (!iREN) own_n = 0;
      else if (done) begin own_n = 0; cnt_n = 0; end
    end else begin
      if (!(dREN || dWEN)) own_n = 0;
      else if (done) begin
        own_n = 0;
        if (iREN && cnt < LIMIT) cnt_n = cnt + 1;
      end
    end
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      own <= 0; cnt <= 0; m_err <= 1'b0;
    end else begin
      own <= own_n; cnt <= cnt_n; m_err <= m_err_n;
    end
  end

  // Every-cycle comparison of the whole output set against the model
  outs_t exp_o, act_o;
  always @(negedge CLK) begin
    exp_o = model_outs();
    act_o = '{iwait: iwait, dwait: dwait, ramREN: ramREN, ramWEN: ramWEN, err: err,
              ramaddr: ramaddr, ramstore: ramstore, iload: iload, dload: dload};
    n_checks++;
    if (act_o === exp_o) n_pass++;
    else $display("FAIL model_cmp t=%0t got iw=%b dw=%b ren=%b wen=%b err=%b addr=%h st=%h il=%h dl=%h want iw=%b dw=%b ren=%b wen=%b err=%b addr=%h st=%h il=%h dl=%h",
                  $time, act_o.iwait, act_o.dwait, act_o.ramREN, act_o.ramWEN, act_o.err,
                  act_o.ramaddr, act_o.ramstore, act_o.iload, act_o.dload,
                  exp_o.iwait, exp_o.dwait, exp_o.ramREN, exp_o.ramWEN, exp_o.err,
                  exp_o.ramaddr, exp_o.ramstore, exp_o.iload, exp_o.dload);
    model_next();
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic idle_inputs();
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
  endtask

  task automatic do_reset();
    idle_inputs();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  int seq[$];
  int d_lows;
  bit i_low;

  initial begin
    idle_inputs();
    nRST = 1'b0;

    // Reset state and single instruction fetch with immediate ACCESS
    do_reset();
    @(negedge CLK);
    chk("rst_iwait", iwait, 1); chk("rst_dwait", dwait, 1);
    chk("rst_ren", ramREN, 0);  chk("rst_err", err, 0);
    step();
    iREN = 1; iaddr = 32'h40; ramstate = ACCESS; ramload = 32'hDEADBEEF;
    @(negedge CLK);
    chk("ifetch_c1_iwait", iwait, 1); chk("ifetch_c1_ren", ramREN, 0);
    step();
    @(negedge CLK);
    chk("ifetch_c2_iwait", iwait, 0); chk("ifetch_c2_iload", iload, 32'hDEADBEEF);
    chk("ifetch_c2_addr", ramaddr, 32'h40); chk("ifetch_c2_dwait", dwait, 1);
    step();
    iREN = 0;
    @(negedge CLK);
    chk("ifetch_c3_iwait", iwait, 1); chk("ifetch_c3_iload", iload, 0);

    // Write (with read also set) held off by BUSY for three cycles
    do_reset();
    dWEN = 1; dREN = 1; daddr = 32'h80; dstore = 32'h1234; ramstate = BUSY;
    @(negedge CLK);
    chk("wr_idle_dwait", dwait, 1);
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("wr_busy_wen", ramWEN, 1); chk("wr_busy_ren", ramREN, 0);
      chk("wr_busy_store", ramstore, 32'h1234); chk("wr_busy_addr", ramaddr, 32'h80);
      chk("wr_busy_dwait", dwait, 1);
      step();
    end
    ramstate = ACCESS;
    @(negedge CLK);
    chk("wr_acc_dwait", dwait, 0); chk("wr_acc_wen", ramWEN, 1); chk("wr_acc_dload", dload, 0);
    step();
    dWEN = 0; dREN = 0; ramstate = FREE;
    @(negedge CLK);
    chk("wr_after_dwait", dwait, 1);

    // ERROR twice then ACCESS: retry completes, err sticks until reset
    do_reset();
    iREN = 1; iaddr = 32'h44; ramstate = ERROR;
    @(negedge CLK);
    chk("err_idle_err", err, 0);
    step();
    @(negedge CLK);
    chk("err_g1_iwait", iwait, 1); chk("err_g1_err", err, 0);
    step();
    @(negedge CLK);
    chk("err_g2_iwait", iwait, 1); chk("err_g2_err", err, 1);
    step();
    ramstate = ACCESS; ramload = 32'h55;
    @(negedge CLK);
    chk("err_acc_iwait", iwait, 0); chk("err_acc_iload", iload, 32'h55);
    step();
    iREN = 0; ramstate = FREE;
    repeat (3) step();
    @(negedge CLK);
    chk("err_sticky", err, 1);
    do_reset();
    @(negedge CLK);
    chk("err_cleared", err, 0);

    // Reset pulsed mid data read
    do_reset();
    dREN = 1; daddr = 32'h90; ramstate = BUSY;
    step();
    @(negedge CLK);
    chk("mid_rst_ren", ramREN, 1); chk("mid_rst_addr", ramaddr, 32'h90);
    #2 nRST = 1'b0;
    #1;
    chk("mid_rst_iwait", iwait, 1); chk("mid_rst_dwait", dwait, 1);
    chk("mid_rst_ren0", ramREN, 0); chk("mid_rst_wen0", ramWEN, 0);
    chk("mid_rst_addr0", ramaddr, 0); chk("mid_rst_store0", ramstore, 0);
    chk("mid_rst_dload0", dload, 0); chk("mid_rst_err0", err, 0);
    ramstate = ACCESS;
    step(); step();
    nRST = 1'b1;
    @(negedge CLK);
    chk("post_rst_no_pulse", dwait, 1); chk("post_rst_ren", ramREN, 0);
    step();
    @(negedge CLK);
    chk("post_rst_new_txn", dwait, 0);
    step();
    dREN = 0;

    // Both sides requesting continuously
    do_reset();
    iREN = 1; dREN = 1; iaddr = 32'h200; daddr = 32'h100; ramstate = ACCESS;
    seq.delete();
    d_lows = 0; i_low = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (!dwait) begin d_lows++; seq.push_back(2); end
      if (!iwait) begin i_low = 1; seq.push_back(1); end
      if (!STARVE && (ramREN || ramWEN)) chk("both_addr_is_daddr", ramaddr, 32'h100);
      step();
    end
`ifdef MEM_ARB_STARVE_EN
    begin
      int exp_seq[6] = '{2, 2, 2, 2, 1, 2};
      chk("starve_seq_len_ok", (seq.size() >= 6), 1);
      for (int k = 0; k < 6 && k < seq.size(); k++) chk("starve_seq", seq[k], exp_seq[k]);
    end
`else
    chk("strict_iwait_never_low", i_low, 0);
    chk("strict_data_grants", d_lows, 10);
`endif

    // Randomized traffic, checked only by the model process
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(posedge CLK); #1;
      nRST = ($urandom_range(249) != 0);
      if ($urandom_range(3) == 0) iREN = $urandom_range(1);
      if ($urandom_range(3) == 0) dREN = $urandom_range(1);
      if ($urandom_range(4) == 0) dWEN = $urandom_range(1);
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      case ($urandom_range(9))
        0, 1, 2, 3, 4: ramstate = ACCESS;
        5, 6:          ramstate = BUSY;
        7, 8:          ramstate = FREE;
        default:       ramstate = ERROR;
      endcase
    end
    nRST = 1'b1;
    idle_inputs();
    repeat (2) @(posedge CLK);
    @(negedge CLK);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
- REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive data grants allowed while an instruction request waits (used only under MEM_ARB_STARVE_EN).
- REQ-002 SHALL have port CLK, input, 1: sole clock; all state updates on the rising edge.
- REQ-003 SHALL have port nRST, input, 1: asynchronous active-low reset.
- REQ-004 SHALL have ports iREN, dREN, dWEN, input, 1 each: cache-side instruction read, data read and data write requests.
- REQ-005 SHALL have ports iaddr, daddr, dstore, input, 32 each: instruction address, data address and write data.
- REQ-006 SHALL have ports iwait, dwait, output, 1 each: active-high stall to the instruction side and the data side.
- REQ-007 SHALL have ports iload, dload, output, 32 each: read data returned to each side.
- REQ-008 SHALL have ports ramREN, ramWEN, output, 1 each; ramaddr, ramstore, output, 32 each: RAM-side request.
- REQ-009 SHALL have ports ramload, input, 32; ramstate, input, ramstate_t: RAM response data and status (FREE, BUSY, ACCESS, ERROR).
- REQ-010 SHALL have port err, output, 1: sticky flag set when ramstate==ERROR is seen during a grant.

Function
- REQ-011 SHALL implement an FSM with states IDLE, IACC and DACC.
- REQ-012 In IDLE: (dREN|dWEN) SHALL go to DACC; else iREN SHALL go to IACC; else stay. Data has priority by default.
- REQ-013 In IDLE all RAM requests SHALL be 0, and iwait=dwait=1.
- REQ-014 In DACC: ramaddr=daddr. dWEN SHALL drive ramWEN=1, ramstore=dstore, ramREN=0. Otherwise ramREN=1, ramWEN=0. dWEN wins if both are set.
- REQ-015 In IACC: ramREN=1, ramaddr=iaddr, ramWEN=0.
- REQ-016 In a granted state, the cycle with ramstate==ACCESS SHALL drive the granted wait low for exactly that cycle, then return to IDLE.
- REQ-017 On a read completion, dload (or iload) SHALL equal ramload combinationally in that same cycle.
- REQ-018 The ungranted side's wait SHALL stay 1 throughout.
- REQ-019 ramstate BUSY or FREE SHALL hold the current state with its wait high.
- REQ-020 ramstate ERROR SHALL keep the wait high, hold the state (retry) and set err.
- REQ-021 If the granted request deasserts before ACCESS, the FSM SHALL return to IDLE next cycle without lowering any wait.
- REQ-022 Consecutive transactions SHALL be separated by exactly one IDLE cycle. Minimum latency is 2 cycles from request to wait low, with RAM ACCESS on the first granted cycle.
- REQ-023 iload and dload SHALL be 0 when not completing a read.

Reset
- REQ-024 nRST low SHALL asynchronously force: state=IDLE, iwait=dwait=1, ramREN=ramWEN=0, ramaddr=ramstore=0, iload=dload=0, err=0, starvation counter=0.
- REQ-025 Reset asserted mid-transaction SHALL abandon it, with no wait-low pulse after release.
- REQ-026 err SHALL clear only on reset.

Configuration
- REQ-027 The macro MEM_ARB_STARVE_EN SHALL control the starvation guard.
- REQ-028 With MEM_ARB_STARVE_EN defined: a counter SHALL count completed data grants taken while iREN was high.
  - When the counter reaches STARVE_LIMIT and iREN is high in IDLE, the FSM SHALL go to IACC despite a data request.
  - The counter SHALL clear on any instruction completion.
- REQ-029 Without MEM_ARB_STARVE_EN: strict data priority, no counter logic synthesized, STARVE_LIMIT ignored.

Structure
- REQ-030 word_t (32-bit) and ramstate_t SHALL come from cpu_types_pkg.
- REQ-031 The arbiter state enum SHALL be added to cpu_types_pkg as arbstate_t.
- REQ-032 The starvation counter SHALL be a sub-module arb_starve_ctr, instantiated only under MEM_ARB_STARVE_EN.
- REQ-033 memory_arbiter SHALL be a single flat module otherwise.

Verification
- REQ-034 iREN=1, iaddr=0x40, RAM returns ACCESS on the first granted cycle with ramload=0xDEADBEEF -> iwait low for 1 cycle at cycle 2, iload=0xDEADBEEF, ramaddr=0x40.
- REQ-035 iREN=dREN=1 held (guard off) -> ramaddr=daddr for every grant, iwait stays 1 indefinitely.
- REQ-036 dWEN=dREN=1, daddr=0x80, dstore=0x1234, RAM BUSY 3 cycles then ACCESS -> ramWEN=1, ramREN=0, dwait low only in the ACCESS cycle.
- REQ-037 Guard on, STARVE_LIMIT=4, iREN and dREN held -> after 4 data completions the 5th grant is IACC, then data resumes.
- REQ-038 ramstate ERROR for 2 cycles then ACCESS -> err=1 and stays 1, the transaction completes, err clears only on nRST.
- REQ-039 nRST pulsed low mid-DACC -> all outputs at reset values immediately, no dwait-low pulse after release.
